// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM encoding, bus phase constants and
// the wait-timer sizing helper.
package apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_CAPT   = 3'd3,
    ST_RESP   = 3'd4
  } apb_state_e;

  typedef struct packed {
    logic psel;
    logic penable;
  } apb_phase_t;

  localparam apb_phase_t PH_IDLE   = '{psel: 1'b0, penable: 1'b0};
  localparam apb_phase_t PH_SETUP  = '{psel: 1'b1, penable: 1'b0};
  localparam apb_phase_t PH_ACCESS = '{psel: 1'b1, penable: 1'b1};

  // Bus phase driven in each requester state; only SETUP and ACCESS select.
  function automatic apb_phase_t phase_of(input apb_state_e st);
    case (st)
      ST_SETUP:  return PH_SETUP;
      ST_ACCESS: return PH_ACCESS;
      default:   return PH_IDLE;
    endcase
  endfunction

  // Wait counter must hold TIMEOUT without wrapping; never narrower than 1 bit.
  function automatic int unsigned timer_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter. Counts cycles with PREADY low, clears when the
// requester leaves ACCESS, flags expiry on the TIMEOUT-th waiting cycle.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned   CW       = timer_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority; saturate so TIMEOUT=0 never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (TIMEOUT != 0) && en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Command/response to APB4 requester: one SETUP+ACCESS transfer per command,
// wait states with timeout abort, read data returned on a response port.
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | PSEL=1, PENABLE=0 for one cycle
//   ACCESS | PSEL=PENABLE=1 until PREADY or timeout
//   CAPT   | bus idle, capture PRDATA from a registered-read slave
//   RESP   | rsp_valid high until rsp_ready
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDWIDTH  = 8,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned RDATA_LAT = 1
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDWIDTH-1:0]    cmd_addr,
  input  logic [DATAWIDTH-1:0]   cmd_wdata,
  input  logic [DATAWIDTH/8-1:0] cmd_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATAWIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDWIDTH-1:0]    PADDR,
  output logic [DATAWIDTH-1:0]   PWDATA,
  output logic [DATAWIDTH/8-1:0] PSTRB,
  input  logic                   PREADY,
  input  logic [DATAWIDTH-1:0]   PRDATA
);

  localparam int unsigned SW = DATAWIDTH / 8;

  apb_state_e           state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDWIDTH-1:0]  paddr_q, paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]        pstrb_q, pstrb_d;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 tmr_clr, tmr_en, tmr_expire;
  apb_phase_t           phase;

  assign tmr_clr = (state_q != ST_ACCESS);
  assign tmr_en  = (state_q == ST_ACCESS) && !PREADY;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  // Next-state and transfer/response register updates.
  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          rdata_d  = '0;
          err_d    = 1'b0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // PREADY wins over a simultaneous expiry.
        if (PREADY) begin
          err_d = 1'b0;
          if (pwrite_q) begin
            rdata_d = '0;
            state_d = ST_RESP;
          end else if (RDATA_LAT == 0) begin
            rdata_d = PRDATA;
            state_d = ST_RESP;
          end else begin
            state_d = ST_CAPT;
          end
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_CAPT: begin
        rdata_d = PRDATA;
        state_d = ST_RESP;
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Registered so cmd_ready stays low while reset is asserted.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign phase     = phase_of(state_q);
  assign PSEL      = phase.psel;
  assign PENABLE   = phase.penable;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge with a behavioural memory slave and stub slaves.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0]  PSTRB;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_master_bridge #(.ADDWIDTH(8), .DATAWIDTH(32), .TIMEOUT(16), .RDATA_LAT(1)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  // Slave: mode 0 = memory (registered read), 1 = PREADY stuck low, 2 = PREADY on late_n-th ACCESS cycle
  int slv_mode = 0;
  int late_n = 16;
  int stub_cnt = 0;
  logic [31:0] slave_mem [0:255] = '{default: 32'h0};

  assign PREADY = (slv_mode == 0) ? (PSEL && PENABLE) :
                  (slv_mode == 1) ? 1'b0 :
                  (PSEL && PENABLE && (stub_cnt == late_n - 1));

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) stub_cnt <= stub_cnt + 1;
    else stub_cnt <= 0;
    if (slv_mode != 0) PRDATA <= 32'h12345678;
    else if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) begin
        for (int b = 0; b < 4; b++)
          if (PSTRB[b]) slave_mem[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
      end else begin
        PRDATA <= slave_mem[PADDR];
      end
    end
  end

  // Bus monitor: ACCESS run length, strobes during reads, PENABLE without prior PSEL
  int acc_run = 0, last_len = 0, strb_bad_cnt = 0, pen_bad_cnt = 0;
  logic prev_psel = 1'b0;
  always @(posedge PCLK) begin
    prev_psel <= PSEL;
    if (PENABLE && !prev_psel) pen_bad_cnt <= pen_bad_cnt + 1;
    if (PSEL && !PWRITE && (PSTRB != 4'h0)) strb_bad_cnt <= strb_bad_cnt + 1;
    if (PSEL && PENABLE) acc_run <= acc_run + 1;
    else if (acc_run != 0) begin
      last_len <= acc_run;
      acc_run  <= 0;
    end
  end

  // Reference memory seen through the bridge
  logic [31:0] ref_mem [0:255] = '{default: 32'h0};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One command end to end. lat = edges from accept to the edge that first sees rsp_valid;
  // rdy_lat = same for cmd_ready returning (or -1).
  task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] st,
                        input int delay, output logic [31:0] rd, output bit er, output int lat, output int rdy_lat);
    int budget, t_acc;
    rd = '0; er = 1'b0; lat = -1; rdy_lat = -1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st; cmd_valid = 1'b1;
    budget = 0;
    while (!cmd_ready && budget < 100) begin @(negedge PCLK); budget++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready got %b want 1 within 100 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    t_acc = cyc + 1;
    rsp_ready = (delay == 0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    budget = 0;
    while (!rsp_valid && budget < 200) begin @(negedge PCLK); budget++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid got %b want 1 within 200 cycles", rsp_valid);
      rsp_ready = 1'b0;
      return;
    end
    lat = cyc + 1 - t_acc;
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < delay; i++) begin
      @(negedge PCLK);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || cmd_ready !== 1'b0 || PSEL !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold: valid=%b rdata=%h err=%b cmd_ready=%b psel=%b want 1 %h %b 0 0",
                 rsp_valid, rsp_rdata, rsp_err, cmd_ready, PSEL, rd, er);
      end
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_drop: rsp_valid got %b want 0 after consume", rsp_valid);
    end
    if (cmd_ready) rdy_lat = cyc + 1 - t_acc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge PCLK);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE} !== 6'b0 ||
        PADDR !== 8'h0 || PWDATA !== 32'h0 || PSTRB !== 4'h0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h strb=%h rdata=%h want all 0",
               {cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE}, PADDR, PWDATA, PSTRB, rsp_rdata);
    end
    PRESET = 1'b0;
    @(negedge PCLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready got %b want 1 after reset release", cmd_ready);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; bit er; int lat, rl;
    do_txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, rl);
    ref_mem[8'h10] = merge(ref_mem[8'h10], 32'hDEADBEEF, 4'hF);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL wr_basic: rdata=%h err=%b lat=%0d want 0 0 3", rd, er, lat);
    end
    do_txn(1'b0, 8'h10, 32'h0, 4'h0, 0, rd, er, lat, rl);
    checks++;
    if (rd !== ref_mem[8'h10] || er !== 1'b0) begin
      errors++;
      $display("FAIL rd_basic: rdata=%h err=%b want %h 0", rd, er, ref_mem[8'h10]);
    end
    checks++;
    if (lat != 4 || rl != 5) begin
      errors++;
      $display("FAIL rd_latency: rsp_valid at T+%0d cmd_ready at T+%0d want T+4 T+5", lat, rl);
    end
    checks++;
    if (last_len != 1) begin
      errors++;
      $display("FAIL zero_wait_access: access cycles got %0d want 1", last_len);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; bit er; int lat, rl, s0;
    do_txn(1'b1, 8'h10, 32'h000000AA, 4'b0001, 0, rd, er, lat, rl);
    ref_mem[8'h10] = merge(ref_mem[8'h10], 32'h000000AA, 4'b0001);
    s0 = strb_bad_cnt;
    do_txn(1'b0, 8'h10, 32'h5555AAAA, 4'hF, 1, rd, er, lat, rl);
    checks++;
    if (rd !== ref_mem[8'h10] || er !== 1'b0) begin
      errors++;
      $display("FAIL strb_merge: rdata=%h err=%b want %h 0", rd, er, ref_mem[8'h10]);
    end
    checks++;
    if (strb_bad_cnt != s0) begin
      errors++;
      $display("FAIL read_pstrb: nonzero PSTRB cycles got %0d want 0", strb_bad_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; bit er; int lat, rl;
    slv_mode = 1;
    do_txn(1'b0, 8'h44, 32'h0, 4'h0, 0, rd, er, lat, rl);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL timeout_rsp: err=%b rdata=%h want 1 00000000", er, rd);
    end
    checks++;
    if (last_len != 16 || lat != 18) begin
      errors++;
      $display("FAIL timeout_len: access cycles=%0d lat=%0d want 16 18", last_len, lat);
    end
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: psel=%b penable=%b want 0 0", PSEL, PENABLE);
    end
    slv_mode = 0;
  endtask

  task automatic test_late_ready();
    logic [31:0] rd; bit er; int lat, rl;
    slv_mode = 2; late_n = 16;
    do_txn(1'b0, 8'h44, 32'h0, 4'h0, 0, rd, er, lat, rl);
    checks++;
    if (er !== 1'b0 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL late_ready: err=%b rdata=%h want 0 12345678", er, rd);
    end
    checks++;
    if (last_len != 16 || lat != 19) begin
      errors++;
      $display("FAIL late_len: access cycles=%0d lat=%0d want 16 19", last_len, lat);
    end
    slv_mode = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd0, rd; bit er0, er; int lat, rl, budget;
    cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'hCAFEF00D; cmd_strb = 4'hF;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    budget = 0;
    while (!cmd_ready && budget < 100) begin @(negedge PCLK); budget++; end
    @(negedge PCLK);
    cmd_write = 1'b0; cmd_wdata = $urandom; cmd_strb = 4'hF;
    budget = 0;
    while (!rsp_valid && budget < 100) begin @(negedge PCLK); budget++; end
    rd0 = rsp_rdata; er0 = rsp_err;
    checks++;
    if (rsp_valid !== 1'b1 || rd0 !== 32'h0 || er0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: valid=%b rdata=%h err=%b want 1 0 0", rsp_valid, rd0, er0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_err !== er0 || cmd_ready !== 1'b0 || PSEL !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: valid=%b rdata=%h err=%b cmd_ready=%b psel=%b want 1 %h %b 0 0",
                 rsp_valid, rsp_rdata, rsp_err, cmd_ready, PSEL, rd0, er0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    ref_mem[8'h30] = merge(ref_mem[8'h30], 32'hCAFEF00D, 4'hF);
    do_txn(1'b0, 8'h30, cmd_wdata, 4'hF, 2, rd, er, lat, rl);
    checks++;
    if (rd !== ref_mem[8'h30] || er !== 1'b0) begin
      errors++;
      $display("FAIL bp_next: rdata=%h err=%b want %h 0", rd, er, ref_mem[8'h30]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit er; int lat, rl, budget, seen;
    slv_mode = 1;
    cmd_write = 1'b0; cmd_addr = 8'h50; cmd_valid = 1'b1;
    budget = 0;
    while (!cmd_ready && budget < 100) begin @(negedge PCLK); budget++; end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    budget = 0;
    while (!(PSEL && PENABLE) && budget < 10) begin @(negedge PCLK); budget++; end
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: psel=%b penable=%b want 0 0 before next edge", PSEL, PENABLE);
    end
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    slv_mode = 0;
    seen = 0;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_rsp: rsp_valid cycles got %0d want 0", seen);
    end
    do_txn(1'b1, 8'h50, 32'h0BADF00D, 4'b1100, 0, rd, er, lat, rl);
    ref_mem[8'h50] = merge(ref_mem[8'h50], 32'h0BADF00D, 4'b1100);
    do_txn(1'b0, 8'h50, 32'h0, 4'h0, 0, rd, er, lat, rl);
    checks++;
    if (rd !== ref_mem[8'h50] || er !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL reset_recover: rdata=%h err=%b lat=%0d want %h 0 4", rd, er, lat, ref_mem[8'h50]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp; bit er, wr; logic [7:0] a; logic [3:0] st; int lat, rl, dly;
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = 8'h20 + 8'($urandom_range(0, 7));
      wd  = $urandom;
      st  = 4'($urandom_range(0, 15));
      dly = $urandom_range(0, 3);
      exp = wr ? 32'h0 : ref_mem[a];
      do_txn(wr, a, wd, st, dly, rd, er, lat, rl);
      if (wr) ref_mem[a] = merge(ref_mem[a], wd, st);
      checks++;
      if (rd !== exp || er !== 1'b0 || lat != (wr ? 3 : 4) || last_len != 1) begin
        errors++;
        $display("FAIL rand_%0d: wr=%b addr=%h rdata=%h err=%b lat=%0d acc=%0d want %h 0 %0d 1",
                 n, wr, a, rd, er, lat, last_len, exp, wr ? 3 : 4);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_timeout();
    test_late_ready();
    test_backpressure();
    test_reset_mid();
    test_random();
    checks++;
    if (pen_bad_cnt != 0) begin
      errors++;
      $display("FAIL penable_protocol: PENABLE without prior PSEL got %0d want 0", pen_bad_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
